// File: rtl/usb_pkg.sv
// -----------------------------------------------------------------------------
// usb_pkg
// Shared definitions for the USB transmit path: the packet codes understood by
// usb_tx (also used by the RX-side protocol logic), the scheduler state
// encoding, and a small helper used to size counters.
// -----------------------------------------------------------------------------
package usb_pkg;

    // Packet codes presented to usb_tx on TX_Packet
    localparam logic [1:0] TX_PACKET_DATA0 = 2'd0;
    localparam logic [1:0] TX_PACKET_ACK   = 2'd1;
    localparam logic [1:0] TX_PACKET_NAK   = 2'd2;
    localparam logic [1:0] TX_PACKET_STALL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_WAIT_ACT = 3'd2,
        ST_ACTIVE   = 3'd3,
        ST_GAP      = 3'd4
    } sched_state_t;

    function automatic int cnt_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// -----------------------------------------------------------------------------
// flex_counter
// Saturating up-counter with synchronous clear and a compare flag.
//   clk             : clock
//   n_rst           : asynchronous active-low reset
//   clear_i         : synchronous clear, wins over count_enable_i
//   count_enable_i  : increment by one this cycle
//   rollover_val_i  : compare value
//   rollover_flag_o : high while the current count equals rollover_val_i
// The count never wraps; it holds at all-ones.
// -----------------------------------------------------------------------------
module flex_counter #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear_i,
    input  logic             count_enable_i,
    input  logic [CNT_W-1:0] rollover_val_i,
    output logic             rollover_flag_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_enable_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign rollover_flag_o = (count_q == rollover_val_i);

endmodule

// File: rtl/usb_tx_sched.sv
// -----------------------------------------------------------------------------
// usb_tx_sched
// Chooses the next packet for usb_tx, issues the start pulse, follows the
// transfer to completion and enforces an idle gap after every transfer.
//   clk, n_rst          : clock, asynchronous active-low reset
//   Hs_Req / Hs_Type    : handshake request (level) and type 1=ACK 2=NAK 3=STALL
//   Data_Req            : DATA0 request (level)
//   Buffer_Occupancy    : bytes waiting in the TX buffer
//   RX_Transfer_Active  : receiver busy, no new start allowed
//   TX_Transfer_Active  : usb_tx is sending
//   TX_Error            : usb_tx reported a failure
//   TX_Start            : one-cycle start pulse to usb_tx
//   TX_Packet           : packet code, held from acceptance to next acceptance
//   Hs_Ack / Data_Ack   : one-cycle request-accepted pulses
//   Busy                : high whenever not idle
//   Tx_Done / Tx_Err    : one-cycle completion / failure pulses
// -----------------------------------------------------------------------------
module usb_tx_sched
    import usb_pkg::*;
#(
    parameter int GAP_CYCLES    = 16,
    parameter int START_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       Hs_Req,
    input  logic [1:0] Hs_Type,
    input  logic       Data_Req,
    input  logic [6:0] Buffer_Occupancy,
    input  logic       RX_Transfer_Active,
    input  logic       TX_Transfer_Active,
    input  logic       TX_Error,
    output logic       TX_Start,
    output logic [1:0] TX_Packet,
    output logic       Hs_Ack,
    output logic       Data_Ack,
    output logic       Busy,
    output logic       Tx_Done,
    output logic       Tx_Err
);

    localparam int CNT_W = $clog2(cnt_max(GAP_CYCLES, START_TIMEOUT)) + 1;

    sched_state_t state_q;
    logic         tx_start_q;
    logic [1:0]   tx_packet_q;
    logic         hs_ack_q;
    logic         data_ack_q;
    logic         busy_q;
    logic         tx_done_q;
    logic         tx_err_q;

    logic             cnt_clear;
    logic             cnt_en;
    logic             cnt_flag;
    logic [CNT_W-1:0] cnt_roll;
    logic             wait_exit;
    logic             hs_type_ok;

    assign hs_type_ok = (Hs_Type == TX_PACKET_ACK) || (Hs_Type == TX_PACKET_NAK) ||
                        (Hs_Type == TX_PACKET_STALL);

    // One counter serves both the start timeout and the gap. It only runs in
    // WAIT_ACT and GAP and is held cleared elsewhere; leaving WAIT_ACT clears
    // it on the same edge so GAP always starts counting from zero.
    assign wait_exit = TX_Error || TX_Transfer_Active || cnt_flag;
    assign cnt_en    = (state_q == ST_WAIT_ACT) || (state_q == ST_GAP);
    assign cnt_clear = !cnt_en || ((state_q == ST_WAIT_ACT) && wait_exit);
    assign cnt_roll  = (state_q == ST_WAIT_ACT) ? CNT_W'(START_TIMEOUT - 1)
                                                : CNT_W'(GAP_CYCLES - 1);

    flex_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk             (clk),
        .n_rst           (n_rst),
        .clear_i         (cnt_clear),
        .count_enable_i  (cnt_en),
        .rollover_val_i  (cnt_roll),
        .rollover_flag_o (cnt_flag)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            tx_start_q  <= 1'b0;
            tx_packet_q <= TX_PACKET_DATA0;
            hs_ack_q    <= 1'b0;
            data_ack_q  <= 1'b0;
            busy_q      <= 1'b0;
            tx_done_q   <= 1'b0;
            tx_err_q    <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            hs_ack_q   <= 1'b0;
            data_ack_q <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (!RX_Transfer_Active) begin
                        if (Hs_Req) begin
                            hs_ack_q <= 1'b1;
                            if (hs_type_ok) begin
                                tx_packet_q <= Hs_Type;
                                state_q     <= ST_START;
                                busy_q      <= 1'b1;
                            end else begin
                                // Illegal type: acknowledge so the requester
                                // releases, but report it and send nothing.
                                tx_err_q <= 1'b1;
                            end
                        end else if (Data_Req) begin
                            data_ack_q  <= 1'b1;
                            // Empty buffer answers the IN token with NAK.
                            tx_packet_q <= (Buffer_Occupancy != '0) ? TX_PACKET_DATA0
                                                                    : TX_PACKET_NAK;
                            state_q     <= ST_START;
                            busy_q      <= 1'b1;
                        end
                    end
                end

                ST_START: begin
                    tx_start_q <= 1'b1;
                    state_q    <= ST_WAIT_ACT;
                end

                ST_WAIT_ACT: begin
                    // Error and timeout take precedence over activity.
                    if (TX_Error || cnt_flag) begin
                        tx_err_q <= 1'b1;
                        state_q  <= ST_GAP;
                    end else if (TX_Transfer_Active) begin
                        state_q <= ST_ACTIVE;
                    end
                end

                ST_ACTIVE: begin
                    if (TX_Error) begin
                        tx_err_q <= 1'b1;
                        state_q  <= ST_GAP;
                    end else if (!TX_Transfer_Active) begin
                        tx_done_q <= 1'b1;
                        state_q   <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (cnt_flag) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign TX_Start  = tx_start_q;
    assign TX_Packet = tx_packet_q;
    assign Hs_Ack    = hs_ack_q;
    assign Data_Ack  = data_ack_q;
    assign Busy      = busy_q;
    assign Tx_Done   = tx_done_q;
    assign Tx_Err    = tx_err_q;

endmodule

// File: tb/tb_usb_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_usb_tx_sched
// Directed and randomized transactions against usb_tx_sched. Expected output
// timelines are derived from the request type, buffer occupancy and the way
// the bench drives the usb_tx side.
// -----------------------------------------------------------------------------
module tb_usb_tx_sched;

    localparam int GAP     = 16;
    localparam int TIMEOUT = 64;

    localparam int M_DONE    = 0;
    localparam int M_ERROR   = 1;
    localparam int M_TIMEOUT = 2;

    logic       clk;
    logic       n_rst;
    logic       Hs_Req;
    logic [1:0] Hs_Type;
    logic       Data_Req;
    logic [6:0] Buffer_Occupancy;
    logic       RX_Transfer_Active;
    logic       TX_Transfer_Active;
    logic       TX_Error;
    logic       TX_Start;
    logic [1:0] TX_Packet;
    logic       Hs_Ack;
    logic       Data_Ack;
    logic       Busy;
    logic       Tx_Done;
    logic       Tx_Err;

    int n_assert;
    int n_fail;

    usb_tx_sched #(
        .GAP_CYCLES    (GAP),
        .START_TIMEOUT (TIMEOUT)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .Hs_Req             (Hs_Req),
        .Hs_Type            (Hs_Type),
        .Data_Req           (Data_Req),
        .Buffer_Occupancy   (Buffer_Occupancy),
        .RX_Transfer_Active (RX_Transfer_Active),
        .TX_Transfer_Active (TX_Transfer_Active),
        .TX_Error           (TX_Error),
        .TX_Start           (TX_Start),
        .TX_Packet          (TX_Packet),
        .Hs_Ack             (Hs_Ack),
        .Data_Ack           (Data_Ack),
        .Busy               (Busy),
        .Tx_Done            (Tx_Done),
        .Tx_Err             (Tx_Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".tx_start"},  TX_Start,  0);
        check({tag, ".tx_packet"}, TX_Packet, 0);
        check({tag, ".hs_ack"},    Hs_Ack,    0);
        check({tag, ".data_ack"},  Data_Ack,  0);
        check({tag, ".busy"},      Busy,      0);
        check({tag, ".tx_done"},   Tx_Done,   0);
        check({tag, ".tx_err"},    Tx_Err,    0);
    endtask

    // Packet the scheduler must send for a given request.
    function automatic logic [1:0] model_packet(input bit hs, input logic [1:0] htype,
                                                input logic [6:0] occ);
        if (hs) return htype;
        return (occ != 0) ? 2'd0 : 2'd2;
    endfunction

    // One full transaction started from IDLE. Observation 0 is the point where
    // the request is raised; acceptance is seen at 1, TX_Start at 2. usb_tx is
    // emulated: activity rises d observations after TX_Start and lasts len, or
    // an error strikes e observations into activity, or nothing happens.
    task automatic txn(input string tag, input bit hs, input logic [1:0] htype,
                       input logic [6:0] occ, input int mode, input int d,
                       input int len, input int e);
        int         i_end;
        logic [1:0] pkt;
        pkt = model_packet(hs, htype, occ);
        case (mode)
            M_DONE:  i_end = 2 + d + len + 1;
            M_ERROR: i_end = 2 + d + e + 1;
            default: i_end = 2 + TIMEOUT;
        endcase

        Buffer_Occupancy = occ;
        if (hs) begin
            Hs_Req  = 1'b1;
            Hs_Type = htype;
        end else begin
            Data_Req = 1'b1;
        end

        for (int i = 1; i <= i_end + GAP; i++) begin
            tick();
            check({tag, ".hs_ack"},    Hs_Ack,    (i == 1) && hs);
            check({tag, ".data_ack"},  Data_Ack,  (i == 1) && !hs);
            check({tag, ".tx_start"},  TX_Start,  i == 2);
            check({tag, ".tx_packet"}, TX_Packet, pkt);
            check({tag, ".tx_done"},   Tx_Done,   (i == i_end) && (mode == M_DONE));
            check({tag, ".tx_err"},    Tx_Err,    (i == i_end) && (mode != M_DONE));
            check({tag, ".busy"},      Busy,      i < i_end + GAP);

            if (i == 1) begin
                if (hs) Hs_Req = 1'b0;
                else    Data_Req = 1'b0;
            end
            if (mode != M_TIMEOUT && i == 2 + d) TX_Transfer_Active = 1'b1;
            if (mode == M_DONE && i == 2 + d + len) TX_Transfer_Active = 1'b0;
            if (mode == M_ERROR && i == 2 + d + e) TX_Error = 1'b1;
            if (mode == M_ERROR && i == 2 + d + e + 1) begin
                TX_Error           = 1'b0;
                TX_Transfer_Active = 1'b0;
            end
        end
    endtask

    initial begin
        n_assert           = 0;
        n_fail             = 0;
        n_rst              = 1'b0;
        Hs_Req             = 1'b0;
        Hs_Type            = 2'd0;
        Data_Req           = 1'b0;
        Buffer_Occupancy   = 7'd0;
        RX_Transfer_Active = 1'b0;
        TX_Transfer_Active = 1'b0;
        TX_Error           = 1'b0;

        // Reset state
        #2;
        check_all_zero("reset");
        #20;
        n_rst = 1'b1;
        tick();
        check_all_zero("post_reset");

        // ACK handshake, 40-cycle transfer, clean completion
        txn("hs_ack", 1'b1, 2'd1, 7'd0, M_DONE, 0, 40, 0);

        // Simultaneous requests: handshake first, data after the gap
        Data_Req = 1'b1;
        txn("both_hs", 1'b1, 2'd3, 7'd10, M_DONE, 2, 6, 0);
        txn("both_data", 1'b0, 2'd0, 7'd10, M_DONE, 1, 12, 0);

        // Data with empty buffer becomes NAK without error
        txn("data_empty", 1'b0, 2'd0, 7'd0, M_DONE, 3, 5, 0);

        // usb_tx never becomes active
        txn("timeout", 1'b1, 2'd2, 7'd0, M_TIMEOUT, 0, 0, 0);

        // Error during activity
        txn("act_err", 1'b0, 2'd0, 7'd77, M_ERROR, 4, 0, 3);

        // Illegal handshake type
        Hs_Req  = 1'b1;
        Hs_Type = 2'd0;
        tick();
        check("illegal.hs_ack",   Hs_Ack,   1);
        check("illegal.tx_err",   Tx_Err,   1);
        check("illegal.busy",     Busy,     0);
        check("illegal.tx_start", TX_Start, 0);
        Hs_Req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("illegal_after.tx_start", TX_Start, 0);
            check("illegal_after.busy",     Busy,     0);
            check("illegal_after.tx_err",   Tx_Err,   0);
        end

        // Receiver busy blocks arbitration
        RX_Transfer_Active = 1'b1;
        Hs_Req             = 1'b1;
        Hs_Type            = 2'd3;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rx_block.hs_ack", Hs_Ack, 0);
            check("rx_block.busy",   Busy,   0);
        end
        RX_Transfer_Active = 1'b0;
        txn("rx_release", 1'b1, 2'd3, 7'd0, M_DONE, 0, 4, 0);

        // Reset in the middle of an active transfer
        Hs_Req  = 1'b1;
        Hs_Type = 2'd2;
        tick();
        check("mid.hs_ack", Hs_Ack, 1);
        Hs_Req = 1'b0;
        tick();
        check("mid.tx_start", TX_Start, 1);
        TX_Transfer_Active = 1'b1;
        tick();
        tick();
        check("mid.busy", Busy, 1);
        n_rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        TX_Transfer_Active = 1'b0;
        #2;
        n_rst = 1'b1;
        tick();
        check_all_zero("mid_reset_rel");
        txn("after_reset", 1'b1, 2'd1, 7'd0, M_DONE, 1, 3, 0);

        // Randomized transactions
        for (int r = 0; r < 10; r++) begin
            bit         hs;
            logic [1:0] ht;
            logic [6:0] occ;
            int         mode;
            int         d;
            int         len;
            int         e;
            hs   = $urandom_range(1, 0) == 1;
            ht   = 2'($urandom_range(3, 1));
            occ  = ($urandom_range(3, 0) == 0) ? 7'd0 : 7'($urandom_range(127, 1));
            mode = ($urandom_range(7, 0) == 0) ? M_TIMEOUT : int'($urandom_range(1, 0));
            d    = $urandom_range(20, 0);
            len  = $urandom_range(30, 1);
            e    = $urandom_range(10, 1);
            txn("rand", hs, ht, occ, mode, d, len, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
